// File: rtl/s2p_deserializer_if.sv
// Serial-in / word-out bundle for s2p_deserializer.
// The slave modport is the deserializer side; master is the bit source plus downstream consumer.
interface s2p_deserializer_if #(
  parameter int WIDTH = 8
);
  logic             bit_in;
  logic             bit_valid;
  logic             sync;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             data_ready;
  logic             parity_err;
  logic             overrun;
  logic             busy;

  modport master (
    output bit_in, bit_valid, sync, data_ready,
    input  data_out, data_valid, parity_err, overrun, busy
  );

  modport slave (
    input  bit_in, bit_valid, sync, data_ready,
    output data_out, data_valid, parity_err, overrun, busy
  );
endinterface

// File: rtl/s2p_deserializer.sv
// Serial-to-parallel deserializer: MSB-first word assembly into a one-word valid/ready holding register.
// Define S2P_PARITY_EN to expect a trailing even-parity bit per word and report parity_err.
module s2p_deserializer #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  s2p_deserializer_if.slave     bus
);

`ifdef S2P_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] shift_reg;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] data_out_q;
  logic             data_valid_q;
  logic             parity_err_q;
  logic             overrun_q;

  logic [WIDTH-1:0] shift_next;
  logic             last_data;
  logic             word_done;
  logic [WIDTH-1:0] word_data;
  logic             word_par;

  assign shift_next = {shift_reg[WIDTH-2:0], bus.bit_in};
  assign last_data  = (bit_cnt == CW'(WIDTH - 1));

  // A bit that arrives with sync always starts a new word, so it can never complete one.
  always_comb begin
    word_done = 1'b0;
    word_data = shift_next;
    word_par  = 1'b0;
    if (bus.bit_valid && !bus.sync) begin
      if (state == SHIFT && last_data && !PAR_EN) begin
        word_done = 1'b1;
      end else if (state == PARITY) begin
        word_done = 1'b1;
        word_data = shift_reg;
        word_par  = PAR_EN & (^{shift_reg, bus.bit_in});
      end
    end
  end

  // NOTE: non-blocking assignments throughout; where two branches assign the same register
  // on one edge (drain then reload of data_valid), the later assignment wins by design.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      shift_reg    <= '0;
      bit_cnt      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      if (data_valid_q && bus.data_ready) begin
        data_valid_q <= 1'b0;
      end

      if (word_done) begin
        if (!data_valid_q || bus.data_ready) begin
          data_out_q   <= word_data;
          data_valid_q <= 1'b1;
          parity_err_q <= word_par;
        end else begin
          overrun_q <= 1'b1;
        end
      end

      if (bus.sync) begin
        state     <= SHIFT;
        overrun_q <= 1'b0;
        if (bus.bit_valid) begin
          shift_reg <= {{(WIDTH-1){1'b0}}, bus.bit_in};
          bit_cnt   <= CW'(1);
        end else begin
          bit_cnt   <= '0;
        end
      end else if (bus.bit_valid) begin
        case (state)
          SHIFT: begin
            shift_reg <= shift_next;
            if (last_data && !PAR_EN) begin
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + CW'(1);
              if (last_data) state <= PARITY;
            end
          end
          PARITY: begin
            bit_cnt <= '0;
            state   <= SHIFT;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.parity_err = parity_err_q;
  assign bus.overrun    = overrun_q;
  assign bus.busy       = (bit_cnt != '0);

endmodule

// File: tb/tb_s2p_deserializer.sv
// Scoreboard bench for s2p_deserializer: directed words, expected words queued at issue time,
// a negedge monitor pops and compares on every valid/ready transfer.
module tb_s2p_deserializer;
  localparam int WIDTH = 8;
`ifdef S2P_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             par;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  s2p_deserializer_if #(.WIDTH(WIDTH)) bus ();
  s2p_deserializer #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [WIDTH-1:0] w, input bit flip);
    exp_t e;
    e.data = w;
    e.par  = PAR_EN ? flip : 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input logic s, input logic v, input logic b);
    bus.sync      = s;
    bus.bit_valid = v;
    bus.bit_in    = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0);
  endtask

  // MSB first, optional sync on bit 0, optional ready raised on the final bit's cycle,
  // then (parity build) an even-parity bit, deliberately inverted when flip is set.
  task automatic send_word(input logic [WIDTH-1:0] w, input bit with_sync,
                           input bit ready_last, input bit flip);
    logic pbit;
    pbit = (^w) ^ flip;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (ready_last && i == 0 && !PAR_EN) bus.data_ready = 1'b1;
      cyc(with_sync && (i == WIDTH - 1), 1'b1, w[i]);
    end
    if (PAR_EN) begin
      if (ready_last) bus.data_ready = 1'b1;
      cyc(1'b0, 1'b1, pbit);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && bus.data_valid === 1'b1 && bus.data_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mon_unexpected: got %0h expected no word", bus.data_out);
        end else begin
          e = exp_q.pop_front();
          check("mon_data", 32'(bus.data_out), 32'(e.data));
          check("mon_parity", 32'(bus.parity_err), 32'(e.par));
        end
      end
    end
  end

  initial begin
    reset          = 1'b1;
    bus.bit_in     = 1'b0;
    bus.bit_valid  = 1'b0;
    bus.sync       = 1'b0;
    bus.data_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_data", 32'(bus.data_out), 32'h0);
    check("rst_valid", 32'(bus.data_valid), 32'h0);
    check("rst_parity", 32'(bus.parity_err), 32'h0);
    check("rst_overrun", 32'(bus.overrun), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    reset = 1'b0;

    // Basic word with the sync on its first bit.
    bus.data_ready = 1'b1;
    push(8'hA5, 1'b0);
    send_word(8'hA5, 1'b1, 1'b0, 1'b0);
    check("t1_valid", 32'(bus.data_valid), 32'h1);
    check("t1_data", 32'(bus.data_out), 32'hA5);
    check("t1_busy", 32'(bus.busy), 32'h0);
    idle(1);
    check("t1_valid_fall", 32'(bus.data_valid), 32'h0);

    // Second word arrives while the first is still held: dropped, overrun set.
    bus.data_ready = 1'b0;
    push(8'h3C, 1'b0);
    send_word(8'h3C, 1'b0, 1'b0, 1'b0);
    send_word(8'hC3, 1'b0, 1'b0, 1'b0);
    check("t2_data", 32'(bus.data_out), 32'h3C);
    check("t2_valid", 32'(bus.data_valid), 32'h1);
    check("t2_overrun", 32'(bus.overrun), 32'h1);
    cyc(1'b1, 1'b0, 1'b0);
    check("t2_overrun_clr", 32'(bus.overrun), 32'h0);
    check("t2_hold", 32'(bus.data_out), 32'h3C);
    bus.data_ready = 1'b1;
    idle(1);
    check("t2_drained", 32'(bus.data_valid), 32'h0);

    // Drain and reload on the same edge.
    bus.data_ready = 1'b0;
    push(8'h5A, 1'b0);
    push(8'h96, 1'b0);
    send_word(8'h5A, 1'b0, 1'b0, 1'b0);
    check("t3_first", 32'(bus.data_out), 32'h5A);
    send_word(8'h96, 1'b0, 1'b1, 1'b0);
    check("t3_valid_kept", 32'(bus.data_valid), 32'h1);
    check("t3_second", 32'(bus.data_out), 32'h96);
    check("t3_no_overrun", 32'(bus.overrun), 32'h0);
    idle(1);
    check("t3_drained", 32'(bus.data_valid), 32'h0);

    // Resync mid-word: the partial word is discarded.
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1);
    check("t4_busy", 32'(bus.busy), 32'h1);
    check("t4_no_word", 32'(bus.data_valid), 32'h0);
    push(8'hFF, 1'b0);
    send_word(8'hFF, 1'b1, 1'b0, 1'b0);
    check("t4_data", 32'(bus.data_out), 32'hFF);
    idle(1);

    // Reset mid-word, then bits without sync are ignored.
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1);
    check("t5_busy", 32'(bus.busy), 32'h1);
    reset = 1'b1;
    idle(1);
    check("t5_rst_data", 32'(bus.data_out), 32'h0);
    check("t5_rst_valid", 32'(bus.data_valid), 32'h0);
    check("t5_rst_busy", 32'(bus.busy), 32'h0);
    check("t5_rst_overrun", 32'(bus.overrun), 32'h0);
    reset = 1'b0;
    send_word(8'hA5, 1'b0, 1'b0, 1'b0);
    check("t5_ignored_valid", 32'(bus.data_valid), 32'h0);
    check("t5_ignored_busy", 32'(bus.busy), 32'h0);

`ifdef S2P_PARITY_EN
    push(8'h01, 1'b0);
    send_word(8'h01, 1'b1, 1'b0, 1'b0);
    check("t6_par_ok_data", 32'(bus.data_out), 32'h01);
    check("t6_par_ok", 32'(bus.parity_err), 32'h0);
    idle(1);
    push(8'h01, 1'b1);
    send_word(8'h01, 1'b0, 1'b0, 1'b1);
    check("t6_par_bad_data", 32'(bus.data_out), 32'h01);
    check("t6_par_bad", 32'(bus.parity_err), 32'h1);
    idle(1);
`endif

    idle(2);
    check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/s2p_deserializer.md
# s2p_deserializer

Serial-to-parallel receive deserializer for the OFDM datapath. It accepts one bit per qualified cycle from the demapper or bit-slicer stage and assembles MSB-first words. Completed words go into a one-word output holding register, which feeds the downstream byte-wide pipeline over a valid/ready handshake. It is the receive-side counterpart of the transmit load/shift register and restores the parallel word that register serialized.

## Interface
Parameters:
- WIDTH, 8, word width in bits (legal range 2..16)

Ports:
- clk  input  1  rising-edge clock; sole clock domain
- reset  input  1  synchronous, active-high reset; sampled on rising edge of clk
- bit_in  input  1  serial data bit
- bit_valid  input  1  bit_in is qualified this cycle
- sync  input  1  word-alignment strobe; restarts word assembly
- data_out  output  WIDTH  assembled word; first received bit at data_out[WIDTH-1]
- data_valid  output  1  data_out holds an undelivered word
- data_ready  input  1  downstream accepts data_out this cycle
- parity_err  output  1  parity status of the word in data_out; qualified by data_valid
- overrun  output  1  sticky: a completed word was dropped
- busy  output  1  a partial word is in the shift register (bit count nonzero)

## Operation
- Reset (reset=1 at clk edge) has priority over everything and forces:
  - state IDLE; shift register and bit count cleared
  - data_out=0, data_valid=0, parity_err=0, overrun=0, busy=0
- State machine:
  - IDLE → SHIFT on sync. Bits are ignored in IDLE.
  - SHIFT → SHIFT while collecting bits.
  - SHIFT → PARITY after WIDTH data bits (macro enabled only).
  - SHIFT or PARITY → SHIFT when the word completes; the bit count restarts at 0.
- Bit accept: in SHIFT, each cycle with bit_valid=1 does shift_reg <= {shift_reg[WIDTH-2:0], bit_in} and increments the bit count.
- sync in SHIFT or PARITY discards the partial word (bit count ← 0). The overrun flag is cleared on that same edge.
- sync with bit_valid=1 in the same cycle: the bit is taken as bit 0 of the new word. This applies in any state, including IDLE.
- Word completion: occurs on the cycle the last bit is accepted (data bit WIDTH-1, or the parity bit when enabled).
  - Holding register empty, or being drained this edge (data_valid & data_ready): load data_out, set data_valid=1, update parity_err.
  - Otherwise: drop the new word, set overrun=1, and leave data_out, data_valid and parity_err unchanged.
- Handshake:
  - A transfer occurs on each edge with data_valid=1 and data_ready=1.
  - data_out and parity_err are held stable while data_valid=1 and data_ready=0.
  - data_valid falls after a transfer unless a new word loads on the same edge. In that case data_valid stays 1 and data_out changes to the new word.
  - data_ready while data_valid=0 has no effect.
- overrun stays set until reset or sync.
- busy = (bit count != 0).

## Timing
- Latency: last bit accepted at edge N → data_valid=1 and data_out valid from edge N (registered outputs, visible the cycle after the bit was presented).
- Maximum throughput is one bit per cycle, giving one word per WIDTH cycles (WIDTH+1 with parity). Back-to-back words need no idle cycles.
- The downstream may hold data_ready low for up to WIDTH-1 bit cycles after data_valid rises without loss.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Reset asserted mid-word aborts the word. The first accepted bit after reset requires a new sync.

## Configuration
- S2P_PARITY_EN defined:
  - Each word carries one extra even-parity bit after the LSB.
  - The parity bit is held in the PARITY state and is not shifted into data_out.
  - parity_err = XOR of the WIDTH data bits and the parity bit, registered with data_out.
  - The word is delivered even when parity_err=1.
- S2P_PARITY_EN undefined:
  - No PARITY state; a word completes on the WIDTH-th bit.
  - parity_err is tied to 0; the port is still present.

## Test plan
- Reset, then sync together with bits 1,0,1,0,0,1,0,1 on consecutive cycles, data_ready=1 → data_out=8'hA5, data_valid high for exactly 1 cycle, busy=0 afterwards.
- Two back-to-back words 8'h3C and 8'hC3, data_ready held 0 until both complete → data_out=8'h3C is retained and overrun=1. A sync then clears overrun to 0.
- data_ready=1 on the same edge the second word completes → data_out goes directly from the first word to the second, with data_valid staying 1.
- Four bits of a word, then sync with bit_valid=1, then seven more bits forming 8'hFF → only 8'hFF is delivered; the partial word is discarded.
- Reset asserted after 3 bits → all outputs 0; bits sent without a new sync are ignored (data_valid stays 0).
- S2P_PARITY_EN: word 8'h01 with parity bit 1 → parity_err=0; with parity bit 0 → parity_err=1. data_out=8'h01 in both cases.
